// File: rtl/mac_stop_pkg.sv
// Shared definitions for the MAC stop stage: FSM states and width helpers.
// RW = 2*DW + clog2(K) is the accumulator width agreed with the MAC unit.
package mac_stop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int addr_w(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int res_w(input int dw, input int k);
        return 2 * dw + $clog2(k);
    endfunction

endpackage

// File: rtl/mac_stop_elem_counter.sv
// Row/column wrap counter over the M x N result matrix, row-major order.
// Latency 1 (advances on the edge after adv); last is combinational from the current count.
module mac_stop_elem_counter
    import mac_stop_pkg::*;
#(
    parameter int M  = 2,
    parameter int N  = 2,
    parameter int RA = addr_w(M),
    parameter int CA = addr_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    output logic [RA-1:0] row,
    output logic [CA-1:0] col,
    output logic          last
);

    logic row_last;
    logic col_last;

    assign row_last = (row == RA'(M - 1));
    assign col_last = (col == CA'(N - 1));
    assign last     = row_last & col_last;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RA'(1);
            end else begin
                col <= col + CA'(1);
            end
        end
    end

endmodule

// File: rtl/mac_stop_accum_writeback.sv
// Sums K consecutive products per result element and writes C[i][j]; done pulses after M*N writes.
// Latency: result_we rises one cycle after the K-th beat. Back-pressure: stalls in WRITE until result_wr_ready.
// Optional MAC_ACC_SIGNED_EN: products are two's complement and are sign-extended into the accumulator.
module mac_stop_accum_writeback
    import mac_stop_pkg::*;
#(
    parameter int M                        = 2,
    parameter int K                        = 2,
    parameter int N                        = 2,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = res_w(DATA_WIDTH_INIT_MATRIX, K)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_in,
    input  logic                                product_valid,
    output logic                                product_ready,
    output logic [addr_w(M)-1:0]                result_row_addr,
    output logic [addr_w(N)-1:0]                result_col_addr,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] result_data,
    output logic                                result_we,
    input  logic                                result_wr_ready,
    output logic                                busy,
    output logic                                done
);

    localparam int RW = DATA_WIDTH_RESULT_MATRIX;
    localparam int RA = addr_w(M);
    localparam int CA = addr_w(N);
    localparam int KW = addr_w(K);

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] acc;
    logic [RW-1:0] ext;
    logic [RW-1:0] sum;
    logic [KW-1:0] k_cnt;
    logic          beat;
    logic          k_last;
    logic          wr_acc;
    logic          cnt_clr;
    logic          elem_last;
    logic [RA-1:0] row;
    logic [CA-1:0] col;

`ifdef MAC_ACC_SIGNED_EN
    assign ext = RW'($signed(product_in));
`else
    assign ext = RW'(product_in);
`endif

    assign product_ready = (state == ACCUM);
    assign result_we     = (state == WRITE);
    assign busy          = (state == ACCUM) || (state == WRITE);
    assign done          = (state == DONE);

    assign beat    = product_valid & product_ready;
    assign k_last  = (k_cnt == KW'(K - 1));
    assign sum     = acc + ext;
    assign wr_acc  = result_we & result_wr_ready;
    assign cnt_clr = (state == IDLE) & start;

    mac_stop_elem_counter #(
        .M  (M),
        .N  (N),
        .RA (RA),
        .CA (CA)
    ) u_elem_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .adv   (wr_acc),
        .row   (row),
        .col   (col),
        .last  (elem_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (beat && k_last) state_nxt = WRITE;
            WRITE:   if (wr_acc) state_nxt = elem_last ? DONE : ACCUM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result and address registers only load on the K-th beat, so they hold through a WRITE stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc             <= '0;
            k_cnt           <= '0;
            result_data     <= '0;
            result_row_addr <= '0;
            result_col_addr <= '0;
        end else if (cnt_clr) begin
            acc   <= '0;
            k_cnt <= '0;
        end else if (beat) begin
            acc <= sum;
            if (k_last) begin
                k_cnt           <= '0;
                result_data     <= sum;
                result_row_addr <= row;
                result_col_addr <= col;
            end else begin
                k_cnt <= k_cnt + KW'(1);
            end
        end else if (wr_acc) begin
            acc <= '0;
        end
    end

endmodule

// File: tb/tb_mac_stop_accum_writeback.sv
// Bench for mac_stop_accum_writeback at M=N=K=2, DW=8: table vectors, corner sequences, random passes.
module tb_mac_stop_accum_writeback;

    localparam int M  = 2;
    localparam int K  = 2;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int PW = 2 * DW;
    localparam int RW = 2 * DW + 1;
    localparam int NP = M * N * K;
    localparam int NE = M * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] product_in;
    logic          product_valid;
    logic          product_ready;
    logic [0:0]    result_row_addr;
    logic [0:0]    result_col_addr;
    logic [RW-1:0] result_data;
    logic          result_we;
    logic          result_wr_ready;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_stop_accum_writeback #(
        .M                      (M),
        .K                      (K),
        .N                      (N),
        .DATA_WIDTH_INIT_MATRIX (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .product_in      (product_in),
        .product_valid   (product_valid),
        .product_ready   (product_ready),
        .result_row_addr (result_row_addr),
        .result_col_addr (result_col_addr),
        .result_data     (result_data),
        .result_we       (result_we),
        .result_wr_ready (result_wr_ready),
        .busy            (busy),
        .done            (done)
    );

    typedef struct {
        logic [PW-1:0] p [NP];
        logic [RW-1:0] e [NE];
        bit            gap;
        int            stall;
        bit            mid_start;
        bit            rnd_rdy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: each element is the modular sum of its K products, extended per build mode.
    function automatic logic [RW-1:0] model_ext(input logic [PW-1:0] p);
`ifdef MAC_ACC_SIGNED_EN
        return RW'($signed(p));
`else
        return RW'(p);
`endif
    endfunction

    task automatic model(input logic [PW-1:0] p [NP], output logic [RW-1:0] e [NE]);
        for (int el = 0; el < NE; el++) begin
            e[el] = '0;
            for (int k = 0; k < K; k++) e[el] = e[el] + model_ext(p[el * K + k]);
        end
    endtask

    task automatic run_pass(input vec_t v);
        int pi = 0;
        int widx = 0;
        int cyc = 0;
        int stall_left = v.stall;
        int since_last = -100;
        bit done_seen = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done_seen && cyc < 400) begin
            if (done) begin
                done_seen = 1;
                chk("writes_before_done", widx, NE);
                chk("done_latency", since_last, 1);
                result_wr_ready = 1'b0;
                product_valid   = 1'b0;
            end else begin
                chk("busy_in_pass", busy, 1'b1);
                if (result_we) begin
                    chk("ready_low_in_write", product_ready, 1'b0);
                    if (widx < NE) begin
                        chk("wr_data", result_data, v.e[widx]);
                        chk("wr_row", result_row_addr, widx / N);
                        chk("wr_col", result_col_addr, widx % N);
                    end else begin
                        chk("extra_write", widx, NE - 1);
                    end
                    if (widx == 0 && stall_left > 0) begin
                        result_wr_ready = 1'b0;
                        stall_left--;
                    end else begin
                        result_wr_ready = v.rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    if (result_wr_ready) begin
                        widx++;
                        since_last = 0;
                    end
                end else begin
                    result_wr_ready = 1'($urandom_range(0, 1));
                end
                if (pi < NP && (!v.gap || cyc % 2 == 0)) begin
                    product_valid = 1'b1;
                    product_in    = v.p[pi];
                    if (product_ready) pi++;
                end else begin
                    product_valid = 1'b0;
                    product_in    = PW'($urandom);
                end
                start = v.mid_start && (cyc == 5 || cyc == 9);
            end
            @(negedge clk);
            cyc++;
            since_last++;
        end
        start = 1'b0;
        if (!done_seen) chk("pass_timeout", 0, 1);
        chk("done_one_cycle", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_product_ready", product_ready, 1'b0);
    endtask

    vec_t tbl [5];
    vec_t rv;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        product_in = '0;
        product_valid = 1'b0;
        result_wr_ready = 1'b0;

        tbl[0].p = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        tbl[0].e = '{17'd3, 17'd7, 17'd11, 17'd15};
        tbl[0].gap = 0; tbl[0].stall = 0; tbl[0].mid_start = 0; tbl[0].rnd_rdy = 0;
        tbl[1] = tbl[0];
        tbl[1].stall = 4;
        tbl[2] = tbl[0];
        tbl[2].gap = 1; tbl[2].mid_start = 1;
        tbl[3].p = '{default: 16'hFFFF};
        tbl[3].e = '{default: 17'h1FFFE};
        tbl[3].gap = 0; tbl[3].stall = 0; tbl[3].mid_start = 0; tbl[3].rnd_rdy = 0;
        // -1 + -2 and 0xFFFF + 0xFFFE give the same 17-bit pattern.
        tbl[4].p = '{16'hFFFF, 16'hFFFE, 16'd0, 16'd9, 16'h8000, 16'h8000, 16'd100, 16'd200};
        tbl[4].e = '{17'h1FFFD, 17'd9, 17'h10000, 17'd300};
        tbl[4].gap = 0; tbl[4].stall = 2; tbl[4].mid_start = 0; tbl[4].rnd_rdy = 1;

        repeat (2) @(negedge clk);
        chk("rst_product_ready", product_ready, 1'b0);
        chk("rst_result_we", result_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result_data", result_data, 0);
        chk("rst_addr", {result_row_addr, result_col_addr}, 0);
        reset = 1'b0;

        // Reset mid-ACCUM after one accepted beat abandons the pass.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        product_valid = 1'b1;
        product_in = 16'd50;
        @(negedge clk);
        chk("pre_reset_accum", product_ready, 1'b1);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_outputs", {product_ready, result_we, busy, done}, 0);
            chk("midrst_data", result_data, 0);
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", {product_ready, result_we, busy, done}, 0);
        end
        product_valid = 1'b0;

        for (int t = 0; t < 5; t++) run_pass(tbl[t]);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NP; i++) rv.p[i] = PW'($urandom);
            model(rv.p, rv.e);
            rv.gap = 1'($urandom_range(0, 1));
            rv.stall = $urandom_range(0, 3);
            rv.mid_start = 1'($urandom_range(0, 1));
            rv.rnd_rdy = 1'b1;
            run_pass(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
